// File: rtl/network_pkg.sv
// rtl/network_pkg.sv - shared state/error types and defaults for the layer dispatcher
package network_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } dispatch_state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_BAD_LAYER = 2'd1,
    ERR_TIMEOUT   = 2'd2,
    ERR_OVERFLOW  = 2'd3
  } err_code_t;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - first-word fall-through result FIFO with overflow pulse
//
// Ports:
//   clock, reset      : clock, asynchronous active-low reset
//   push, push_data   : write request and word (dropped when full without a pop)
//   pop               : read request, ignored when empty
//   head              : current head word (valid while !empty)
//   full, empty, count: occupancy status
//   overflow          : combinational pulse on a dropped push
module result_fifo
  import network_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/network_dispatch.sv
// rtl/network_dispatch.sv - dispatches a layer command and DDR3 stream to one of several engines
//
// Ports:
//   clock, reset                     : clock, asynchronous active-low reset
//   Layer, Start                     : engine select and command strobe
//   DDR3_Input, DDR3_operands/weights/biases, DDR3_ready : upstream word stream
//   eng_data, eng_*_valid, eng_start : routed stream and start pulse to engines
//   eng_result, eng_result_valid, eng_done : engine return path
//   Result, Result_Valid, Result_Ready, Fifo_Count : buffered results
//   Computing, Done, Error, Error_Code : status
module network_dispatch
  import network_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int NUM_ENGINES    = 3,
  parameter int SEL_WIDTH      = $clog2(NUM_ENGINES),
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [SEL_WIDTH-1:0]                  Layer,
  input  logic                                  Start,
  input  logic [DATA_WIDTH-1:0]                 DDR3_Input,
  input  logic                                  DDR3_operands,
  input  logic                                  DDR3_weights,
  input  logic                                  DDR3_biases,
  output logic                                  DDR3_ready,
  output logic [DATA_WIDTH-1:0]                 eng_data,
  output logic [NUM_ENGINES-1:0]                eng_operands_valid,
  output logic [NUM_ENGINES-1:0]                eng_weights_valid,
  output logic [NUM_ENGINES-1:0]                eng_biases_valid,
  output logic [NUM_ENGINES-1:0]                eng_start,
  input  logic [NUM_ENGINES-1:0][DATA_WIDTH-1:0] eng_result,
  input  logic [NUM_ENGINES-1:0]                eng_result_valid,
  input  logic [NUM_ENGINES-1:0]                eng_done,
  output logic [DATA_WIDTH-1:0]                 Result,
  output logic                                  Result_Valid,
  input  logic                                  Result_Ready,
  output logic                                  Computing,
  output logic                                  Done,
  output logic                                  Error,
  output logic [1:0]                            Error_Code,
  output logic [$clog2(FIFO_DEPTH):0]           Fifo_Count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SEL_WIDTH:0] NUM_ENG_W = (SEL_WIDTH+1)'(NUM_ENGINES);
  localparam logic [CW-1:0]      READY_LIM = CW'(FIFO_DEPTH - 2);
  localparam logic [TW-1:0]      TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  dispatch_state_t        state, next_state;
  err_code_t              error_code_r;
  logic                   error_r;
  logic [SEL_WIDTH-1:0]   sel;
  logic [NUM_ENGINES-1:0] sel_onehot;
  logic [TW-1:0]          idle_cnt;
  logic                   fwd_op, fwd_wt, fwd_bs;
  logic [DATA_WIDTH-1:0]  fwd_data;

  logic                   layer_ok, start_ok, start_bad;
  logic                   run_ready, accept, res_valid_sel, done_sel;
  logic                   collecting, push, activity, timeout_hit;
  logic [DATA_WIDTH-1:0]  fifo_head;
  logic                   fifo_full_unused, fifo_empty, fifo_overflow;
  logic [CW-1:0]          fifo_count;

  assign sel_onehot    = NUM_ENGINES'(1) << sel;
  assign layer_ok      = ({1'b0, Layer} < NUM_ENG_W);
  assign start_ok      = Start && (state == ST_IDLE) && layer_ok;
  assign start_bad     = Start && (state == ST_IDLE) && !layer_ok;
  // Two entries of headroom cover results already in flight when the stream stalls.
  assign run_ready     = (state == ST_RUN) && (fifo_count < READY_LIM);
  assign accept        = run_ready && (DDR3_operands || DDR3_weights || DDR3_biases);
  assign res_valid_sel = eng_result_valid[sel];
  assign done_sel      = eng_done[sel];
  assign collecting    = (state == ST_RUN) || (state == ST_DRAIN);
  assign push          = collecting && res_valid_sel;
  assign activity      = accept || res_valid_sel;
  assign timeout_hit   = (state == ST_RUN) && !activity && (idle_cnt == TO_LAST);

  result_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (eng_result[sel]),
    .pop       (Result_Ready),
    .head      (fifo_head),
    .full      (fifo_full_unused),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (fifo_overflow)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start_ok) next_state = ST_LOAD;
      ST_LOAD:  next_state = ST_RUN;
      ST_RUN: begin
        if (done_sel)         next_state = ST_DRAIN;
        else if (timeout_hit) next_state = ST_IDLE;
      end
      // A push landing this cycle means the FIFO is not really empty yet.
      ST_DRAIN: if (fifo_empty && !push) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    DDR3_ready         = run_ready;
    Computing          = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_DRAIN);
    Done               = (state == ST_DONE);
    eng_start          = (state == ST_LOAD) ? sel_onehot : '0;
    eng_operands_valid = fwd_op ? sel_onehot : '0;
    eng_weights_valid  = fwd_wt ? sel_onehot : '0;
    eng_biases_valid   = fwd_bs ? sel_onehot : '0;
  end

  // Selection, forwarding register and idle counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel      <= '0;
      idle_cnt <= '0;
      fwd_op   <= 1'b0;
      fwd_wt   <= 1'b0;
      fwd_bs   <= 1'b0;
      fwd_data <= '0;
    end else begin
      if (start_ok) sel <= Layer;
      if ((state != ST_RUN) || activity) idle_cnt <= '0;
      else                               idle_cnt <= idle_cnt + 1'b1;
      fwd_op <= run_ready && DDR3_operands;
      fwd_wt <= run_ready && DDR3_weights;
      fwd_bs <= run_ready && DDR3_biases;
      if (accept) fwd_data <= DDR3_Input;
    end
  end

  // Error pulse and sticky code
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      error_r      <= 1'b0;
      error_code_r <= ERR_NONE;
    end else begin
      error_r <= 1'b0;
      if (start_ok) error_code_r <= ERR_NONE;
      if (start_bad) begin
        error_r      <= 1'b1;
        error_code_r <= ERR_BAD_LAYER;
      end
      if (fifo_overflow) begin
        error_r      <= 1'b1;
        error_code_r <= ERR_OVERFLOW;
      end
      if (timeout_hit) begin
        error_r      <= 1'b1;
        error_code_r <= ERR_TIMEOUT;
      end
    end
  end

  assign eng_data     = fwd_data;
  assign Result       = fifo_empty ? '0 : fifo_head;
  assign Result_Valid = !fifo_empty;
  assign Error        = error_r;
  assign Error_Code   = error_code_r;
  assign Fifo_Count   = fifo_count;

endmodule

// File: tb/tb_network_dispatch.sv
// tb/tb_network_dispatch.sv - directed scoreboard bench for network_dispatch
module tb_network_dispatch;

  localparam int DW = 32;
  localparam int NE = 3;
  localparam int FD = 16;
  localparam int TO = 20;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [1:0]        Layer;
  logic              Start;
  logic [DW-1:0]     DDR3_Input;
  logic              DDR3_operands, DDR3_weights, DDR3_biases;
  logic              DDR3_ready;
  logic [DW-1:0]     eng_data;
  logic [NE-1:0]     eng_operands_valid, eng_weights_valid, eng_biases_valid, eng_start;
  logic [NE-1:0][DW-1:0] eng_result;
  logic [NE-1:0]     eng_result_valid, eng_done;
  logic [DW-1:0]     Result;
  logic              Result_Valid, Result_Ready;
  logic              Computing, Done, Error;
  logic [1:0]        Error_Code;
  logic [4:0]        Fifo_Count;

  int passed = 0;
  int total  = 0;
  int op_cnt[NE];
  int wt_cnt[NE];
  int bs_cnt[NE];
  int done_cnt;
  int pops;
  logic [DW-1:0] res_q[$];
  logic [DW-1:0] fwd_q[$];

  always #5 clock = ~clock;

  network_dispatch #(
    .DATA_WIDTH     (DW),
    .NUM_ENGINES    (NE),
    .FIFO_DEPTH     (FD),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .Layer              (Layer),
    .Start              (Start),
    .DDR3_Input         (DDR3_Input),
    .DDR3_operands      (DDR3_operands),
    .DDR3_weights       (DDR3_weights),
    .DDR3_biases        (DDR3_biases),
    .DDR3_ready         (DDR3_ready),
    .eng_data           (eng_data),
    .eng_operands_valid (eng_operands_valid),
    .eng_weights_valid  (eng_weights_valid),
    .eng_biases_valid   (eng_biases_valid),
    .eng_start          (eng_start),
    .eng_result         (eng_result),
    .eng_result_valid   (eng_result_valid),
    .eng_done           (eng_done),
    .Result             (Result),
    .Result_Valid       (Result_Valid),
    .Result_Ready       (Result_Ready),
    .Computing          (Computing),
    .Done               (Done),
    .Error              (Error),
    .Error_Code         (Error_Code),
    .Fifo_Count         (Fifo_Count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_counts();
    for (int e = 0; e < NE; e++) begin
      op_cnt[e] = 0;
      wt_cnt[e] = 0;
      bs_cnt[e] = 0;
    end
    done_cnt = 0;
    pops     = 0;
  endtask

  // One clock: pops are scored at the negedge before the edge that performs
  // them, forwarded strobes and Done are observed just after the edge.
  task automatic tick();
    logic [DW-1:0] exp;
    @(negedge clock);
    if (Result_Valid && Result_Ready) begin
      exp = (res_q.size() > 0) ? res_q.pop_front() : 32'hx;
      check("result_pop", Result, exp);
      pops = pops + 1;
    end
    @(posedge clock);
    #1;
    for (int e = 0; e < NE; e++) begin
      op_cnt[e] += int'(eng_operands_valid[e]);
      wt_cnt[e] += int'(eng_weights_valid[e]);
      bs_cnt[e] += int'(eng_biases_valid[e]);
    end
    if ((|eng_operands_valid) || (|eng_weights_valid) || (|eng_biases_valid)) begin
      exp = (fwd_q.size() > 0) ? fwd_q.pop_front() : 32'hx;
      check("fwd_data", eng_data, exp);
    end
    done_cnt += int'(Done);
  endtask

  task automatic start_cmd(input logic [1:0] l);
    Layer = l;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output int n);
    n = 0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (Done) begin
        n = i + 1;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int pops_at_done;
    Layer = '0; Start = 0; DDR3_Input = '0;
    DDR3_operands = 0; DDR3_weights = 0; DDR3_biases = 0;
    eng_result = '0; eng_result_valid = '0; eng_done = '0; Result_Ready = 0;
    clear_counts();

    // Reset and first command
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_ddr3_ready", DDR3_ready, 0);
    check("rst_eng_data", eng_data, 0);
    check("rst_op_valid", eng_operands_valid, 0);
    check("rst_wt_valid", eng_weights_valid, 0);
    check("rst_bs_valid", eng_biases_valid, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_result", Result, 0);
    check("rst_result_valid", Result_Valid, 0);
    check("rst_computing", Computing, 0);
    check("rst_done", Done, 0);
    check("rst_error", Error, 0);
    check("rst_error_code", Error_Code, 0);
    check("rst_fifo_count", Fifo_Count, 0);
    start_cmd(2'd1);
    check("t1_eng_start", eng_start, 3'b010);
    check("t1_computing", Computing, 1);
    tick();
    check("t1_eng_start_off", eng_start, 3'b000);
    eng_done = 3'b010;
    tick();
    eng_done = '0;
    done_cnt = 0;
    wait_done(10, n);
    check("t1_done_seen", n != 0, 1);
    repeat (2) tick();
    check("t1_done_once", done_cnt, 1);
    check("t1_idle", Computing, 0);

    // Layer 0 stream and results
    clear_counts();
    Result_Ready = 1'b1;
    start_cmd(2'd0);
    tick();
    check("t2_ddr3_ready", DDR3_ready, 1);
    for (int i = 0; i < 18; i++) begin
      DDR3_Input    = 32'h1000 + i;
      DDR3_operands = (i < 8);
      DDR3_weights  = (i >= 8) && (i < 17);
      DDR3_biases   = (i == 17);
      fwd_q.push_back(DDR3_Input);
      tick();
    end
    DDR3_operands = 0; DDR3_weights = 0; DDR3_biases = 0;
    for (int r = 0; r < 4; r++) begin
      eng_result[0]    = 32'hA000 + 32'(r * 7);
      eng_result[1]    = 32'hBAD0 + 32'(r);
      eng_result_valid = (r == 1) ? 3'b011 : 3'b001;
      res_q.push_back(eng_result[0]);
      tick();
    end
    eng_result_valid = '0;
    eng_done = 3'b001;
    tick();
    eng_done = '0;
    wait_done(20, n);
    pops_at_done = pops;
    check("t2_done_seen", n != 0, 1);
    check("t2_pops_before_done", pops_at_done, 4);
    repeat (2) tick();
    check("t2_op_cnt0", op_cnt[0], 8);
    check("t2_wt_cnt0", wt_cnt[0], 9);
    check("t2_bs_cnt0", bs_cnt[0], 1);
    check("t2_other_engines", op_cnt[1] + op_cnt[2] + wt_cnt[1] + wt_cnt[2] + bs_cnt[1] + bs_cnt[2], 0);
    check("t2_res_q_empty", res_q.size(), 0);
    check("t2_fwd_q_empty", fwd_q.size(), 0);
    check("t2_done_once", done_cnt, 1);

    // Bad layer
    start_cmd(2'd3);
    check("t3_error", Error, 1);
    check("t3_error_code", Error_Code, 1);
    check("t3_computing", Computing, 0);
    check("t3_eng_start", eng_start, 0);
    tick();
    check("t3_error_pulse", Error, 0);
    check("t3_code_hold", Error_Code, 1);
    check("t3_no_start", eng_start, 0);

    // Backpressure and overflow on engine 2
    clear_counts();
    Result_Ready = 1'b0;
    start_cmd(2'd2);
    tick();
    for (int i = 0; i < 16; i++) begin
      eng_result[2]    = 32'h200 + i;
      eng_result_valid = 3'b100;
      res_q.push_back(eng_result[2]);
      tick();
      if (i == 12) begin
        check("t4_ready_at13", DDR3_ready, 1);
        check("t4_count13", Fifo_Count, 13);
      end
      if (i == 13) begin
        check("t4_ready_at14", DDR3_ready, 0);
        check("t4_count14", Fifo_Count, 14);
      end
    end
    check("t4_full_count", Fifo_Count, 16);
    check("t4_no_error_full", Error, 0);
    eng_result[2] = 32'hDEAD;
    tick();
    check("t4_ovf_error", Error, 1);
    check("t4_ovf_code", Error_Code, 3);
    check("t4_ovf_count", Fifo_Count, 16);
    check("t4_ovf_continues", Computing, 1);
    Result_Ready  = 1'b1;
    eng_result[2] = 32'h300;
    res_q.push_back(eng_result[2]);
    tick();
    check("t4_pushpop_count", Fifo_Count, 16);
    check("t4_pushpop_no_error", Error, 0);
    eng_result_valid = '0;
    eng_done = 3'b100;
    tick();
    eng_done = '0;
    wait_done(40, n);
    check("t4_done_seen", n != 0, 1);
    tick();
    check("t4_res_q_empty", res_q.size(), 0);
    check("t4_pops", pops, 17);
    check("t4_code_hold", Error_Code, 3);
    check("t4_done_once", done_cnt, 1);

    // Timeout with no traffic
    clear_counts();
    Result_Ready = 1'b0;
    start_cmd(2'd0);
    check("t5_code_cleared", Error_Code, 0);
    n = 0;
    while (!Error && n < 40) begin
      tick();
      n++;
    end
    check("t5_timeout_cycles", n, TO + 1);
    check("t5_code", Error_Code, 2);
    check("t5_idle", Computing, 0);
    check("t5_no_done", done_cnt, 0);

    // Same-cycle result and done, then reset in DRAIN
    clear_counts();
    start_cmd(2'd1);
    check("t6_code_cleared", Error_Code, 0);
    tick();
    eng_result[1]    = 32'hC0DE;
    eng_result[0]    = 32'hBAD0;
    eng_result_valid = 3'b011;
    eng_done         = 3'b010;
    res_q.push_back(32'hC0DE);
    tick();
    eng_result_valid = '0;
    eng_done = '0;
    check("t6_count", Fifo_Count, 1);
    check("t6_result", Result, 32'hC0DE);
    check("t6_draining", Computing, 1);
    tick();
    check("t6_drain_hold", Computing, 1);
    reset = 1'b0;
    #1;
    check("t6_rst_count", Fifo_Count, 0);
    check("t6_rst_valid", Result_Valid, 0);
    check("t6_rst_computing", Computing, 0);
    res_q.delete();
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    check("t6_no_done", done_cnt, 0);
    check("t6_idle", Computing, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

endmodule
